// File: rtl/ahblite_slave_arbiter.sv
// ahblite_slave_arbiter
// Per-slave master arbiter for an AHB-Lite bus matrix. Picks which master's
// address phase reaches the slave using round-robin order. A master keeps the
// grant while its burst continues or while it holds HMASTLOCK. The arbiter also
// records which master owns the data phase.
// All state is registered and advances only on cycles where hready=1.
// Optional build macro: ARB_HOLD_LIMIT_EN. When it is defined, a burst that has
// held the grant for MAX_HOLD beats gives way to other requesters. It never
// overrides a locked sequence.
module ahblite_slave_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETN,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] seq,
  input  logic [NUM_MASTERS-1:0] lock,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] addr_grant,
  output logic [3:0]             addr_grant_idx,
  output logic                   addr_active,
  output logic [NUM_MASTERS-1:0] data_sel,
  output logic                   data_active,
  output logic                   locked
);

  localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDXW-1:0] RR_RESET = IDXW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_LOCKED
  } state_e;

  if (NUM_MASTERS < 1 || NUM_MASTERS > 16 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("ahblite_slave_arbiter: NUM_MASTERS must be 1..16 and MAX_HOLD >= 1");
  end

  state_e                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]          rr_q, rr_d;
  logic [NUM_MASTERS-1:0]   data_q, data_d;

  logic                     owner_req, owner_seq, owner_lock;
  logic                     keep_lock, keep_burst;
  logic                     hold_expired;

  logic [2*NUM_MASTERS-1:0] req2;
  logic [NUM_MASTERS-1:0]   rot;
  logic [4:0]               rr_start;
  logic                     rr_found;
  logic [IDXW-1:0]          rr_idx;
  logic [NUM_MASTERS-1:0]   rr_oh;

  // The owner's request qualifiers, taken through the one-hot grant mask
  always_comb begin
    owner_req  = |(grant_q & req);
    owner_seq  = |(grant_q & seq);
    owner_lock = |(grant_q & lock);
  end

  // Round-robin search: rotate the requests so that rr+1 lands at bit 0,
  // take the lowest set bit, then map it back to an absolute index
  always_comb begin
    int unsigned abs_idx;
    abs_idx  = 0;
    rr_start = 5'(rr_q) + 5'd1;
    req2     = {req, req};
    rot      = NUM_MASTERS'(req2 >> rr_start);
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned p = 0; p < NUM_MASTERS; p++) begin
      if (rot[p] && !rr_found) begin
        rr_found = 1'b1;
        abs_idx  = (32'(rr_start) + p) % NUM_MASTERS;
        rr_idx   = abs_idx[IDXW-1:0];
      end
    end
    rr_oh = NUM_MASTERS'(1) << rr_idx;
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] hold_q, hold_d;

  // The burst hold expires only when some other master is waiting
  always_comb begin
    hold_expired = (hold_q >= HW'(MAX_HOLD)) && (|(req & ~grant_q));
  end

  // Count kept burst beats and saturate; clear whenever arbitration runs
  always_comb begin
    hold_d = hold_q;
    if (hready) begin
      if (keep_lock) begin
        hold_d = hold_q;
      end else if (keep_burst) begin
        hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;
      end else begin
        hold_d = '0;
      end
    end
  end

  // Hold counter register
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) hold_q <= '0;
    else          hold_q <= hold_d;
  end
`else
  // Without the hold limit, bursts keep the grant indefinitely
  always_comb begin
    hold_expired = 1'b0;
  end
`endif

  // Grant policy: a lock hold beats a burst hold, and a burst hold beats round-robin
  always_comb begin
    keep_lock  = (state_q == ST_LOCKED) && owner_lock;
    keep_burst = (state_q == ST_OWNED) && owner_req && owner_seq && !hold_expired;
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    data_d     = data_q;
    if (hready) begin
      data_d = grant_q & req;
      if (keep_lock) begin
        state_d = ST_LOCKED;
      end else if (keep_burst) begin
        state_d = owner_lock ? ST_LOCKED : ST_OWNED;
      end else if (rr_found) begin
        grant_d = rr_oh;
        rr_d    = rr_idx;
        state_d = (|(rr_oh & lock)) ? ST_LOCKED : ST_OWNED;
      end else begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    end
  end

  // State, grant, pointer and data-phase registers
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= RR_RESET;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
    end
  end

  // Output decodes of the registered state
  always_comb begin
    addr_grant     = grant_q;
    addr_active    = |(grant_q & req);
    data_sel       = data_q;
    data_active    = |data_q;
    locked         = (state_q == ST_LOCKED);
    addr_grant_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) addr_grant_idx = 4'(i);
    end
  end

endmodule

// File: tb/tb_ahblite_slave_arbiter.sv
// Testbench for ahblite_slave_arbiter. It runs directed scenarios and then
// random traffic. Every output is compared, each cycle, against a reference
// model that tracks the owner and the round-robin pointer as integers.
module tb_ahblite_slave_arbiter;

  localparam int N    = 2;
  localparam int MH   = 4;
  localparam int HMAX = (1 << ($clog2(MH) + 1)) - 1;

  logic         HCLK = 1'b0;
  logic         HRESETN;
  logic [N-1:0] req, seq, lock;
  logic         hready;
  logic [N-1:0] addr_grant, data_sel;
  logic [3:0]   addr_grant_idx;
  logic         addr_active, data_active, locked;

  int total = 0;
  int bad   = 0;

  int           m_owner, m_rr, m_hold;
  bit           m_locked;
  logic [N-1:0] m_data;

  ahblite_slave_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .req(req), .seq(seq), .lock(lock),
    .hready(hready), .addr_grant(addr_grant), .addr_grant_idx(addr_grant_idx),
    .addr_active(addr_active), .data_sel(data_sel), .data_active(data_active),
    .locked(locked)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_rr     = N - 1;
    m_hold   = 0;
    m_locked = 0;
    m_data   = '0;
  endtask

  function automatic bit model_expired();
`ifdef ARB_HOLD_LIMIT_EN
    return (m_hold >= MH) && ((req & ~onehot(m_owner)) != '0);
`else
    return 1'b0;
`endif
  endfunction

  // One accepted cycle: the lock hold wins over the burst hold, and the burst
  // hold wins over a round-robin scan
  task automatic model_edge();
    int nxt;
    bit exp_now;
    if (!hready) return;
    exp_now = model_expired();
    m_data  = onehot(m_owner) & req;
    if (m_locked && m_owner >= 0 && lock[m_owner]) begin
      // locked owner keeps the grant
    end else if (!m_locked && m_owner >= 0 && req[m_owner] && seq[m_owner] && !exp_now) begin
      m_hold   = (m_hold < HMAX) ? m_hold + 1 : HMAX;
      m_locked = lock[m_owner];
    end else begin
      nxt = -1;
      for (int k = 1; k <= N; k++) begin
        if (req[(m_rr + k) % N]) begin
          nxt = (m_rr + k) % N;
          break;
        end
      end
      m_hold  = 0;
      m_owner = nxt;
      if (nxt >= 0) begin
        m_rr     = nxt;
        m_locked = lock[nxt];
      end else begin
        m_locked = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant"},  32'(addr_grant),     32'(onehot(m_owner)));
    chk({tag, ".idx"},    32'(addr_grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk({tag, ".active"}, 32'(addr_active),    32'((onehot(m_owner) & req) != '0));
    chk({tag, ".dsel"},   32'(data_sel),       32'(m_data));
    chk({tag, ".dact"},   32'(data_active),    32'(m_data != '0));
    chk({tag, ".locked"}, 32'(locked),         32'(m_locked));
  endtask

  // Drive one cycle from the falling edge, let the rising edge pass, then check
  task automatic cyc(input string tag, input logic [N-1:0] r, input logic [N-1:0] s,
                     input logic [N-1:0] l, input logic h);
    req = r; seq = s; lock = l; hready = h;
    @(posedge HCLK);
    model_edge();
    #1;
    check_all(tag);
    @(negedge HCLK);
  endtask

  initial begin
    HRESETN = 1'b0;
    req = '0; seq = '0; lock = '0; hready = 1'b1;
    model_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    check_all("reset");
    chk("reset.grant0", 32'(addr_grant), 32'd0);
    HRESETN = 1'b1;

    // First request: the grant appears one cycle later and data_sel one cycle after that
    cyc("t1a", 2'b01, 2'b00, 2'b00, 1'b1);
    chk("t1.grant01", 32'(addr_grant), 32'd1);
    cyc("t1b", 2'b01, 2'b00, 2'b00, 1'b1);
    chk("t1.dsel01", 32'(data_sel), 32'd1);
    chk("t1.nolock", 32'(locked), 32'd0);
    cyc("t1c", 2'b00, 2'b00, 2'b00, 1'b1);

    // Both masters request single transfers, so the grant alternates
    for (int i = 0; i < 6; i++) cyc("t2", 2'b11, 2'b00, 2'b00, 1'b1);

    // Master 0 runs an INCR4 burst, with a 3-cycle wait state in beat 2
    cyc("t3pre", 2'b10, 2'b00, 2'b00, 1'b1);
    cyc("t3b1", 2'b11, 2'b00, 2'b00, 1'b1);
    chk("t3.m0won", 32'(addr_grant), 32'd1);
    cyc("t3b2", 2'b11, 2'b01, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) cyc("t3wait", 2'b11, 2'b01, 2'b00, 1'b0);
    chk("t3.waithold", 32'(addr_grant), 32'd1);
    cyc("t3b3", 2'b11, 2'b01, 2'b00, 1'b1);
    cyc("t3b4", 2'b11, 2'b01, 2'b00, 1'b1);
    chk("t3.stillm0", 32'(addr_grant), 32'd1);
    cyc("t3end", 2'b10, 2'b00, 2'b00, 1'b1);
    chk("t3.tom1", 32'(addr_grant), 32'd2);

    // Master 1 holds a lock while its own req toggles
    cyc("t4a", 2'b01, 2'b00, 2'b00, 1'b1);
    cyc("t4b", 2'b11, 2'b00, 2'b10, 1'b1);
    chk("t4.locked", 32'(locked), 32'd1);
    cyc("t4c", 2'b01, 2'b00, 2'b10, 1'b1);
    cyc("t4d", 2'b11, 2'b00, 2'b10, 1'b1);
    cyc("t4e", 2'b01, 2'b00, 2'b10, 1'b1);
    chk("t4.keep10", 32'(addr_grant), 32'd2);
    cyc("t4f", 2'b11, 2'b00, 2'b00, 1'b1);
    chk("t4.rel01", 32'(addr_grant), 32'd1);
    chk("t4.unlock", 32'(locked), 32'd0);

    // Reset is asserted in the middle of a burst owned by master 1
    cyc("t5a", 2'b11, 2'b00, 2'b00, 1'b1);
    cyc("t5b", 2'b11, 2'b10, 2'b00, 1'b1);
    chk("t5.dsel10", 32'(data_sel), 32'd2);
    #2;
    HRESETN = 1'b0;
    #1;
    model_reset();
    check_all("t5rst");
    chk("t5.dsel0", 32'(data_sel), 32'd0);
    @(negedge HCLK);
    HRESETN = 1'b1;
    cyc("t5c", 2'b11, 2'b00, 2'b00, 1'b1);
    chk("t5.first01", 32'(addr_grant), 32'd1);

    // Master 0 runs a long SEQ burst against a waiting master 1, first unlocked, then locked
    cyc("t6i", 2'b00, 2'b00, 2'b00, 1'b1);
    cyc("t6p", 2'b10, 2'b00, 2'b00, 1'b1);
    cyc("t6g", 2'b11, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) cyc("t6k", 2'b11, 2'b01, 2'b00, 1'b1);
    chk("t6.held", 32'(addr_grant), 32'd1);
    cyc("t6x", 2'b11, 2'b01, 2'b00, 1'b1);
`ifdef ARB_HOLD_LIMIT_EN
    chk("t6.limit", 32'(addr_grant), 32'd2);
`else
    chk("t6.nolimit", 32'(addr_grant), 32'd1);
`endif
    cyc("t6i2", 2'b00, 2'b00, 2'b00, 1'b1);
    cyc("t6p2", 2'b10, 2'b00, 2'b00, 1'b1);
    cyc("t6g2", 2'b11, 2'b00, 2'b01, 1'b1);
    for (int i = 0; i < 7; i++) cyc("t6l", 2'b11, 2'b01, 2'b01, 1'b1);
    chk("t6.lockhold", 32'(addr_grant), 32'd1);

    // Random traffic, with a single reset pulse partway through
    for (int i = 0; i < 800; i++) begin
      logic [N-1:0] r, s, l;
      r = N'($urandom);
      s = N'($urandom);
      l = '0;
      for (int b = 0; b < N; b++) l[b] = ($urandom_range(0, 5) == 0);
      if (i == 400) begin
        HRESETN = 1'b0;
        #1;
        model_reset();
        check_all("rndrst");
        @(negedge HCLK);
        HRESETN = 1'b1;
      end
      cyc("rnd", r, s, l, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahblite_slave_arbiter.md
Name: ahblite_slave_arbiter

Overview:
Per-slave master arbiter for the AHB-Lite bus matrix. Each slave stage has one instance. It decides which master's address phase is routed to the slave, and tracks which master owns the data phase so the slave stage can steer HWDATA/HREADYOUT/HRESP. Policy is round-robin, with burst continuation and HMASTLOCK held to the current owner. Grant is fully registered and changes only when the slave stage signals HREADY.

Parameters:
NUM_MASTERS, 2, number of requesting masters (1..16).
MAX_HOLD, 16, max consecutive accepted burst beats before forced re-arbitration (used only with ARB_HOLD_LIMIT_EN).

Ports:
HCLK  input  1  clock
HRESETN  input  1  reset, asynchronous assert, active-low
req  input  NUM_MASTERS  master i presents a non-IDLE transfer decoded to this slave
seq  input  NUM_MASTERS  master i HTRANS is SEQ or BUSY (burst continuation)
lock  input  NUM_MASTERS  master i HMASTLOCK
hready  input  1  slave-stage HREADY; address phase accepted this cycle
addr_grant  output  NUM_MASTERS  registered one-hot address-phase owner (all-zero = none)
addr_grant_idx  output  4  binary index of addr_grant (0 when none)
addr_active  output  1  |(addr_grant & req): a real transfer is presented to the slave
data_sel  output  NUM_MASTERS  registered one-hot data-phase owner
data_active  output  1  |data_sel
locked  output  1  arbiter is in LOCKED state

Behaviour:
- Reset values: addr_grant=0, addr_grant_idx=0, data_sel=0, locked=0, state=IDLE, rr pointer=NUM_MASTERS-1 (so master 0 wins first), hold counter=0.
- All registered state updates only on posedge HCLK with hready=1. With hready=0, every register holds, regardless of req/seq/lock changes.
- States:
  - IDLE: no owner.
  - OWNED: owner is addr_grant.
  - LOCKED: owner is addr_grant and lock[owner]=1.
- Next-grant rule, evaluated when hready=1:
  - LOCKED and lock[owner]=1 -> keep owner, even if req[owner]=0 (IDLE cycles inside a locked sequence).
  - OWNED and req[owner]&seq[owner] -> keep owner (burst not broken).
  - Otherwise, round-robin: scan indices rr+1, rr+2, ... modulo NUM_MASTERS and pick the first with req=1. If none, go to IDLE with addr_grant=0.
- Transitions when hready=1:
  - To LOCKED whenever the chosen owner has lock=1.
  - LOCKED -> OWNED/IDLE when lock[owner]=0 at an hready cycle; round-robin applies in that same cycle.
- rr updates to the new owner index only when a new owner is picked by round-robin, not on a hold.
- Latency: a req first asserted in cycle t (hready=1) gives addr_grant no earlier than t+1.
- Data phase: on hready=1, data_sel <= addr_grant & req (the transfer just accepted); otherwise data_sel holds. An IDLE address phase therefore yields data_sel=0 next.
- Simultaneous requests: resolved purely by rr order. Requests from non-owners during a hold are ignored until the hold ends.
- Owner drops req with seq=0 and no lock: re-arbitrate that cycle; the owner may be regranted only after all others in rr order.
- NUM_MASTERS=1: degenerates to grant=req registered; rr is a no-op.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous). After reset release, the first hready cycle re-arbitrates from master 0.
- addr_grant_idx and addr_active are combinational decodes of registered state and current req; no other combinational path from inputs to outputs.

Optional Feature:
ARB_HOLD_LIMIT_EN
- Defined:
  - A counter increments on each hready=1 cycle in which the owner is kept by the burst rule; it clears on any owner change.
  - When the count reaches MAX_HOLD and any other master has req=1, the burst hold is overridden and round-robin runs.
  - LOCKED is never overridden.
  - Counter width is clog2(MAX_HOLD)+1, saturating.
- Undefined: no counter exists; bursts hold indefinitely.

Test Plan:
- Reset, then req=2'b01 at cycle 1 with hready=1 -> addr_grant=01 at cycle 2, data_sel=01 at cycle 3, locked=0.
- req=2'b11 held, seq=0, hready=1 every cycle -> addr_grant alternates 01,10,01,10; data_sel follows one cycle later.
- Master 0 4-beat INCR4 (seq=0,1,1,1) with req[1]=1 throughout -> addr_grant=01 for 4 cycles, then 10; hready=0 in beat 2 for 3 cycles extends the hold by 3 cycles with no grant change.
- Master 1 lock=1 with req toggling 1,0,1 and req[0]=1 -> addr_grant stays 10, locked=1; lock drops -> next hready cycle addr_grant=01, locked=0.
- Assert HRESETN=0 mid-burst with data_sel=10 -> all outputs 0 asynchronously; after release with req=11, first grant is 01.
- With ARB_HOLD_LIMIT_EN, MAX_HOLD=4: master 0 continuous SEQ, req[1]=1 -> master 0 held for 4 kept beats after its initial grant, then addr_grant=10; with master 0 also locked, no switch occurs.
